// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline's fetch and data ports, the arbiter and the memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ack,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );

    // Pipeline and memory view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ack,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage,
// data first, with fetch forced through after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [1:0]  SIZE_WORD  = 2'b10;

    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    // Next-state, arbitration and registered-output values.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.if_req) begin
                    starve_d = '0;
                end
                if (bus.d_req && !(bus.if_req && starve_q == STARVE_LIM)) begin
                    state_d     = SERVE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_size_d  = bus.d_size;
                    if (bus.if_req && starve_q < STARVE_LIM) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (bus.if_req) begin
                    state_d     = SERVE_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_size_d  = SIZE_WORD;
                    starve_d    = '0;
                end
            end
            SERVE_IF, SERVE_D: begin
                // MEM_* stay frozen until the memory completes.
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == SERVE_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed reset/starvation/zero-wait runs,
// and random traffic against a transaction-level expectation model.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          SMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [1:0]  mem_size;
        logic        if_ack;
        logic        d_ack;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
        logic        busy;
    } obs_t;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [1:0]  d_size;
        logic        mem_ack;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        in_t  in;
        obs_t exp;
    } vec_t;

    int   total  = 0;
    int   bad    = 0;
    bit   chk_on = 1'b0;

    // Expectation model: who owns the memory and whether the reply is being returned.
    obs_t m       = '0;
    int   m_owner = 0;      // 0 nobody, 1 fetch, 2 data
    bit   m_in_resp = 1'b0;
    int   m_starve = 0;

    function automatic obs_t sample();
        obs_t o;
        o.mem_req   = bus.mem_req;
        o.mem_we    = bus.mem_we;
        o.mem_addr  = bus.mem_addr;
        o.mem_wdata = bus.mem_wdata;
        o.mem_size  = bus.mem_size;
        o.if_ack    = bus.if_ack;
        o.d_ack     = bus.d_ack;
        o.if_rdata  = bus.if_rdata;
        o.d_rdata   = bus.d_rdata;
        o.busy      = busy;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit want_f;
        bit want_d;
        want_f   = bus.if_req;
        want_d   = bus.d_req;
        m.if_ack = 1'b0;
        m.d_ack  = 1'b0;
        if (m_in_resp) begin
            m_in_resp = 1'b0;
            m_owner   = 0;
        end else if (m_owner != 0) begin
            if (bus.mem_ack) begin
                m.mem_req = 1'b0;
                m_in_resp = 1'b1;
                if (m_owner == 1) begin
                    m.if_ack   = 1'b1;
                    m.if_rdata = bus.mem_rdata;
                end else begin
                    m.d_ack = 1'b1;
                    if (!m.mem_we) m.d_rdata = bus.mem_rdata;
                end
            end
        end else begin
            if (want_d && !(want_f && m_starve == SMAX)) begin
                m_owner     = 2;
                m.mem_req   = 1'b1;
                m.mem_we    = bus.d_we;
                m.mem_addr  = bus.d_addr;
                m.mem_wdata = bus.d_wdata;
                m.mem_size  = bus.d_size;
                if (want_f) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            end else if (want_f) begin
                m_owner     = 1;
                m.mem_req   = 1'b1;
                m.mem_we    = 1'b0;
                m.mem_addr  = bus.if_addr;
                m.mem_wdata = 32'h0;
                m.mem_size  = 2'b10;
                m_starve    = 0;
            end
            if (!want_f) m_starve = 0;
        end
        m.busy = (m_owner != 0);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m         = '0;
            m_owner   = 0;
            m_in_resp = 1'b0;
            m_starve  = 0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) check("model", sample(), m);
    end

    function automatic in_t mk_in(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                                  input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] ds,
                                  input bit ma, input logic [31:0] mr);
        in_t v;
        v = '{if_req: ir, if_addr: ia, d_req: dr, d_we: dw, d_addr: da, d_wdata: dwd,
              d_size: ds, mem_ack: ma, mem_rdata: mr};
        return v;
    endfunction

    function automatic obs_t mk_ob(input bit mq, input bit mw, input logic [31:0] maddr,
                                   input logic [31:0] mwd, input logic [1:0] ms, input bit ia,
                                   input bit da, input logic [31:0] ird, input logic [31:0] drd,
                                   input bit b);
        obs_t o;
        o = '{mem_req: mq, mem_we: mw, mem_addr: maddr, mem_wdata: mwd, mem_size: ms,
              if_ack: ia, d_ack: da, if_rdata: ird, d_rdata: drd, busy: b};
        return o;
    endfunction

    task automatic apply(input in_t v);
        bus.if_req    = v.if_req;
        bus.if_addr   = v.if_addr;
        bus.d_req     = v.d_req;
        bus.d_we      = v.d_we;
        bus.d_addr    = v.d_addr;
        bus.d_wdata   = v.d_wdata;
        bus.d_size    = v.d_size;
        bus.mem_ack   = v.mem_ack;
        bus.mem_rdata = v.mem_rdata;
    endtask

    task automatic drive_random();
        if (!bus.if_req || bus.if_ack) begin
            bus.if_req  = ($urandom % 3) != 0;
            bus.if_addr = $urandom;
        end
        if (!bus.d_req || bus.d_ack) begin
            bus.d_req   = ($urandom % 2) != 0;
            bus.d_we    = 1'($urandom % 2);
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_size  = 2'($urandom_range(0, 2));
        end
        bus.mem_ack   = bus.mem_req ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
        bus.mem_rdata = $urandom;
    endtask

    localparam logic [31:0] FW  = 32'h0050_0093;
    localparam logic [31:0] FW2 = 32'h00A0_0113;
    localparam logic [31:0] LD  = 32'hCAFE_F00D;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;
    localparam logic [31:0] JNK = 32'h1234_5678;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    vec_t tbl[16];
    int   got[10];
    int   exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    initial begin
        int n;
        int cyc;
        apply('0);

        // Fetch with two wait states, store, simultaneous load+fetch, stray MEM_ACKs.
        tbl[0]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0),          mk_ob(1, 0, 32'h100, 0, 2, 0, 0, 0, 0, 1)};
        tbl[1]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0),          mk_ob(1, 0, 32'h100, 0, 2, 0, 0, 0, 0, 1)};
        tbl[2]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0),          mk_ob(1, 0, 32'h100, 0, 2, 0, 0, 0, 0, 1)};
        tbl[3]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 0, 1, FW),         mk_ob(0, 0, 32'h100, 0, 2, 1, 0, FW, 0, 1)};
        tbl[4]  = '{mk_in(0, 32'h100, 0, 0, 0, 0, 0, 1, BAD),        mk_ob(0, 0, 32'h100, 0, 2, 0, 0, FW, 0, 0)};
        tbl[5]  = '{mk_in(0, 0, 1, 1, 32'h2000, DB, 0, 0, 0),        mk_ob(1, 1, 32'h2000, DB, 0, 0, 0, FW, 0, 1)};
        tbl[6]  = '{mk_in(0, 0, 1, 1, 32'h2000, DB, 0, 0, JNK),      mk_ob(1, 1, 32'h2000, DB, 0, 0, 0, FW, 0, 1)};
        tbl[7]  = '{mk_in(0, 0, 1, 1, 32'h2000, DB, 0, 1, JNK),      mk_ob(0, 1, 32'h2000, DB, 0, 0, 1, FW, 0, 1)};
        tbl[8]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, BAD),              mk_ob(0, 1, 32'h2000, DB, 0, 0, 0, FW, 0, 0)};
        tbl[9]  = '{mk_in(1, 32'h104, 1, 0, 32'h3000, 0, 2, 0, 0),   mk_ob(1, 0, 32'h3000, 0, 2, 0, 0, FW, 0, 1)};
        tbl[10] = '{mk_in(1, 32'h104, 1, 0, 32'h3000, 0, 2, 1, LD),  mk_ob(0, 0, 32'h3000, 0, 2, 0, 1, FW, LD, 1)};
        tbl[11] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 1, BAD),        mk_ob(0, 0, 32'h3000, 0, 2, 0, 0, FW, LD, 0)};
        tbl[12] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0),          mk_ob(1, 0, 32'h104, 0, 2, 0, 0, FW, LD, 1)};
        tbl[13] = '{mk_in(1, 32'h104, 0, 0, 0, 0, 0, 1, FW2),        mk_ob(0, 0, 32'h104, 0, 2, 1, 0, FW2, LD, 1)};
        tbl[14] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, BAD),              mk_ob(0, 0, 32'h104, 0, 2, 0, 0, FW2, LD, 0)};
        tbl[15] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 1, BAD),              mk_ob(0, 0, 32'h104, 0, 2, 0, 0, FW2, LD, 0)};

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_state", sample(), '0);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].in);
            @(negedge clk);
            check($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end

        // Async reset in the middle of a data transaction.
        apply(mk_in(0, 0, 1, 0, 32'h4000, 0, 2, 0, 0));
        @(negedge clk);
        check_bit("rst_pre_mem_req", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        apply('0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d", i), sample(), '0);
        end

        // Both requesters held: four data grants, then one forced fetch, repeated.
        apply(mk_in(1, 32'h500, 1, 0, 32'h600, 0, 2, 0, 0));
        n   = 0;
        cyc = 0;
        for (int i = 0; i < 10; i++) got[i] = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.if_ack) begin got[n] = 1; n++; end
            else if (bus.d_ack) begin got[n] = 2; n++; end
            if (n == 10) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = $urandom;
        end
        if (n < 10) begin
            total++;
            bad++;
            $display("FAIL starve_timeout: got %0d acks want 10", n);
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got[i] != exp_seq[i]) begin
                bad++;
                $display("FAIL starve_order%0d: got owner %0d want %0d", i, got[i], exp_seq[i]);
            end
        end
        apply('0);
        repeat (3) @(negedge clk);

        // Zero-wait memory, data request held: D_ACK every third cycle.
        apply(mk_in(0, 0, 1, 1, 32'h700, 32'h55AA_55AA, 2, 0, 0));
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_bit($sformatf("zw_dack_c%0d", c), bus.d_ack, (c % 3) == 2);
            if (c == 8) bus.d_req = 1'b0;
            bus.mem_ack = bus.mem_req;
        end
        apply('0);
        repeat (3) @(negedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            @(negedge clk);
        end
        apply('0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch stage and its memory stage.
- Each side uses a req/ack handshake; the memory side has variable latency.
- Data accesses (store on MEM_WRITE, load on MEM_READ2) take priority over fetch, with a bounded-starvation guarantee for fetch.
- The pipeline stalls the requesting stage while its ACK is low.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting before fetch is forced through (range 1..15).

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- IF_REQ  in  1  fetch request; held until IF_ACK.
- IF_ADDR  in  ADDR_W  fetch address.
- IF_RDATA  out  DATA_W  fetched word; valid while IF_ACK=1.
- IF_ACK  out  1  one-cycle completion pulse to fetch.
- D_REQ  in  1  data request; held until D_ACK.
- D_WE  in  1  1=store, 0=load.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  store data.
- D_SIZE  in  2  00 byte, 01 half, 10 word.
- D_RDATA  out  DATA_W  load data; valid while D_ACK=1.
- D_ACK  out  1  one-cycle completion pulse to data.
- MEM_REQ  out  1  memory request; held until MEM_ACK.
- MEM_WE  out  1  write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  write data.
- MEM_SIZE  out  2  access size.
- MEM_RDATA  in  DATA_W  read data; valid with MEM_ACK.
- MEM_ACK  in  1  memory completion, one cycle.
- BUSY  out  1  1 in any state other than IDLE.

Behaviour:
- States: IDLE, SERVE_IF, SERVE_D, RESP. All outputs are registered.
- Reset (async, RST_N=0): state=IDLE, starvation counter=0, every output=0 (including RDATA registers). MEM_REQ drops immediately even mid-transaction; an in-flight transaction is abandoned and no ACK is issued.
- IDLE, arbitration when IF_REQ and/or D_REQ are sampled high:
  - only D_REQ: grant data.
  - only IF_REQ: grant fetch.
  - both: grant data unless starve_cnt==STARVE_MAX, in which case grant fetch.
- Grant: latch the owner's ADDR/WE/WDATA/SIZE into MEM_* registers and set MEM_REQ=1 the next cycle. A fetch grant forces MEM_WE=0, MEM_SIZE=10, MEM_WDATA=0.
- Starvation counter (4 bits):
  - increments when both request in IDLE and data is granted;
  - clears when fetch is granted, or when IF_REQ=0 in IDLE;
  - saturates at STARVE_MAX.
- SERVE_IF / SERVE_D:
  - MEM_REQ and all MEM_* outputs are held stable until MEM_ACK.
  - On MEM_ACK: capture MEM_RDATA into the owner's RDATA register (loads and fetches only; D_RDATA is unchanged for stores), drop MEM_REQ next cycle, go to RESP.
  - MEM_ACK in the same cycle MEM_REQ first rises is legal (zero-wait memory).
- RESP: owner's ACK=1 for exactly this cycle; next state IDLE. Requests sampled in RESP are ignored, so a REQ held through ACK is re-arbitrated in IDLE as a new transaction.
- Latency: grant-sample → MEM_REQ is 1 cycle; MEM_ACK → requester ACK is 1 cycle. With zero-wait memory a transaction occupies 3 cycles (IDLE, SERVE, RESP).
- Dropped request: an owner deasserting REQ mid-transaction is a protocol violation. The transaction still completes and ACK still pulses.
- MEM_ACK outside SERVE_* is ignored.
- IF_RDATA and D_RDATA hold their last captured value between transactions.

Test Plan:
- Reset: assert RST_N=0 mid-SERVE_D with MEM_REQ=1 → MEM_REQ, BUSY, ACKs and RDATA all 0 in the same cycle; after release, IDLE with no spurious ACK.
- Single fetch: IF_REQ=1, IF_ADDR=0x100, memory acks after 2 wait cycles with 0x00500093 → MEM_REQ rises 1 cycle after the request is sampled, with MEM_WE=0 and MEM_SIZE=10; IF_ACK=1 for one cycle with IF_RDATA=0x00500093.
- Store: D_REQ=1, D_WE=1, D_ADDR=0x2000, D_WDATA=0xDEADBEEF, D_SIZE=00 → MEM_WE=1 and MEM_* match and stay stable until MEM_ACK; D_ACK pulses; D_RDATA unchanged.
- Simultaneous requests: IF_REQ and D_REQ both rise in the same cycle, load from 0x3000 → data is served first; fetch is served on the next IDLE arbitration.
- Starvation: STARVE_MAX=4, IF_REQ held high, D_REQ held high continuously → exactly 4 data transactions, then 1 fetch, then data resumes; counter is 0 after the fetch grant.
- Zero-wait back-to-back: MEM_ACK tied to MEM_REQ, D_REQ held through 3 transactions → each takes 3 cycles; D_ACK pulses every third cycle.
